// File: rtl/matrix_memory_stream_if.sv
// Bus bundle for the matrix register file: read/generator ports, full-matrix write
// port, and the row-serial load/store handshakes.
interface matrix_memory_stream_if #(
  parameter int DIM     = 4,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 8,
  parameter int CONST_W = 16
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ROW_W = DIM * DATA_W;
  localparam int MAT_W = DIM * DIM * DATA_W;

  logic [IDX_W-1:0]   rd1_idx;
  logic [IDX_W-1:0]   rd2_idx;
  logic [1:0]         gen_mode;
  logic [CONST_W-1:0] gen_const;
  logic [MAT_W-1:0]   rd1_data;
  logic [MAT_W-1:0]   rd2_data;
  logic               wr_en;
  logic [IDX_W-1:0]   wr_idx;
  logic [MAT_W-1:0]   wr_data;
  logic               ld_start;
  logic [IDX_W-1:0]   ld_idx;
  logic               ld_valid;
  logic               ld_ready;
  logic [ROW_W-1:0]   ld_row;
  logic               ld_done;
  logic               st_start;
  logic [IDX_W-1:0]   st_idx;
  logic               st_valid;
  logic               st_ready;
  logic [ROW_W-1:0]   st_row;
  logic               st_last;

  modport master (
    output rd1_idx, rd2_idx, gen_mode, gen_const, wr_en, wr_idx, wr_data,
    output ld_start, ld_idx, ld_valid, ld_row, st_start, st_idx, st_ready,
    input  rd1_data, rd2_data, ld_ready, ld_done, st_valid, st_row, st_last
  );

  modport slave (
    input  rd1_idx, rd2_idx, gen_mode, gen_const, wr_en, wr_idx, wr_data,
    input  ld_start, ld_idx, ld_valid, ld_row, st_start, st_idx, st_ready,
    output rd1_data, rd2_data, ld_ready, ld_done, st_valid, st_row, st_last
  );
endinterface

// File: rtl/matrix_memory_stream.sv
// Matrix register file with forwarding read ports, a constant generator on port 2 and
// independent row-serial load/store engines.
module matrix_memory_stream #(
  parameter int DIM     = 4,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 8,
  parameter int CONST_W = 16
) (
  input  logic CLK,
  input  logic RST_N,
  matrix_memory_stream_if.slave bus
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DIM);
  localparam int NEL   = DIM * DIM;
  localparam int ROW_W = DIM * DATA_W;
  localparam int MAT_W = NEL * DATA_W;
  localparam logic [IDX_W:0]   DEPTH_V = (IDX_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(DIM - 1);

  typedef enum logic {L_IDLE, L_ACTIVE} ld_state_t;
  typedef enum logic {S_IDLE, S_STREAM} st_state_t;

  logic [MAT_W-1:0] mem_data [DEPTH];

  ld_state_t        ld_state_reg, ld_state_next;
  logic [CNT_W-1:0] ld_cnt_reg;
  logic [IDX_W-1:0] ld_slot_reg;
  logic             ld_done_reg;
  logic             ld_beat, ld_last;

  st_state_t        st_state_reg, st_state_next;
  logic [CNT_W-1:0] st_cnt_reg;
  logic [MAT_W-1:0] st_buf_reg;
  logic [ROW_W-1:0] st_row_reg;
  logic [MAT_W-1:0] st_snap;
  logic             st_beat, st_final;

  logic             rd1_ok, rd2_ok, st_ok;
  logic [MAT_W-1:0] rd1_mem, rd2_mem, bcast_mat, diag_mat;
  logic [DATA_W-1:0] const_ext;

  // Slot storage; indices at or beyond DEPTH never match a slot, so those writes vanish.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    logic [MAT_W-1:0] slot_reg;
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        slot_reg <= '0;
      end else if (bus.wr_en && bus.wr_idx == IDX_W'(gi)) begin
        slot_reg <= bus.wr_data;
      end else if (ld_beat && ld_slot_reg == IDX_W'(gi)) begin
        slot_reg[ROW_W*(DIM-1-int'(ld_cnt_reg)) +: ROW_W] <= bus.ld_row;
      end
    end
    assign mem_data[gi] = slot_reg;
  end

  assign rd1_ok = {1'b0, bus.rd1_idx} < DEPTH_V;
  assign rd2_ok = {1'b0, bus.rd2_idx} < DEPTH_V;
  assign st_ok  = {1'b0, bus.st_idx}  < DEPTH_V;

  always_comb begin
    rd1_mem = '0;
    rd2_mem = '0;
    st_snap = '0;
    if (rd1_ok) rd1_mem = (bus.wr_en && bus.wr_idx == bus.rd1_idx) ? bus.wr_data : mem_data[bus.rd1_idx];
    if (rd2_ok) rd2_mem = (bus.wr_en && bus.wr_idx == bus.rd2_idx) ? bus.wr_data : mem_data[bus.rd2_idx];
    if (st_ok)  st_snap = (bus.wr_en && bus.wr_idx == bus.st_idx)  ? bus.wr_data : mem_data[bus.st_idx];
  end

  assign const_ext = DATA_W'(bus.gen_const);

  // Element e sits at row e/DIM, column e%DIM; element 0 occupies the MSBs.
  for (genvar gi = 0; gi < NEL; gi++) begin : g_gen
    assign bcast_mat[(NEL-1-gi)*DATA_W +: DATA_W] = const_ext;
    assign diag_mat[(NEL-1-gi)*DATA_W +: DATA_W]  = ((gi / DIM) == (gi % DIM)) ? const_ext : '0;
  end

  assign bus.rd1_data = rd1_mem;

  always_comb begin
    bus.rd2_data = rd2_mem;
    case (bus.gen_mode)
      2'b01:   bus.rd2_data = bcast_mat;
      2'b10:   bus.rd2_data = diag_mat;
      2'b11:   bus.rd2_data = '0;
      default: bus.rd2_data = rd2_mem;
    endcase
  end

  // Load engine: a full-matrix write takes the memory for the cycle, so the load stalls.
  assign bus.ld_ready = (ld_state_reg == L_ACTIVE) && !bus.wr_en;
  assign ld_beat      = bus.ld_ready && bus.ld_valid;
  assign ld_last      = ld_beat && (ld_cnt_reg == LAST_ROW);
  assign bus.ld_done  = ld_done_reg;

  always_comb begin
    ld_state_next = ld_state_reg;
    case (ld_state_reg)
      L_IDLE:   if (bus.ld_start) ld_state_next = L_ACTIVE;
      L_ACTIVE: if (ld_last)      ld_state_next = L_IDLE;
      default:  ld_state_next = L_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ld_state_reg <= L_IDLE;
      ld_cnt_reg   <= '0;
      ld_slot_reg  <= '0;
      ld_done_reg  <= 1'b0;
    end else begin
      ld_state_reg <= ld_state_next;
      ld_done_reg  <= ld_last;
      if (ld_state_reg == L_IDLE && bus.ld_start) begin
        ld_cnt_reg  <= '0;
        ld_slot_reg <= bus.ld_idx;
      end else if (ld_beat) begin
        ld_cnt_reg <= ld_cnt_reg + 1'b1;
      end
    end
  end

  // Store engine streams from a private snapshot so later writes cannot disturb it.
  assign st_beat      = (st_state_reg == S_STREAM) && bus.st_ready;
  assign st_final     = st_beat && (st_cnt_reg == LAST_ROW);
  assign bus.st_valid = (st_state_reg == S_STREAM);
  assign bus.st_last  = (st_state_reg == S_STREAM) && (st_cnt_reg == LAST_ROW);
  assign bus.st_row   = st_row_reg;

  always_comb begin
    st_state_next = st_state_reg;
    case (st_state_reg)
      S_IDLE:   if (bus.st_start) st_state_next = S_STREAM;
      S_STREAM: if (st_final)     st_state_next = S_IDLE;
      default:  st_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      st_state_reg <= S_IDLE;
      st_cnt_reg   <= '0;
      st_buf_reg   <= '0;
      st_row_reg   <= '0;
    end else begin
      st_state_reg <= st_state_next;
      if (st_state_reg == S_IDLE && bus.st_start) begin
        st_buf_reg <= st_snap;
        st_cnt_reg <= '0;
        st_row_reg <= st_snap[MAT_W-1 -: ROW_W];
      end else if (st_beat && !st_final) begin
        st_cnt_reg <= st_cnt_reg + 1'b1;
        st_row_reg <= st_buf_reg[ROW_W*(DIM-2-int'(st_cnt_reg)) +: ROW_W];
      end
    end
  end
endmodule

// File: tb/tb_matrix_memory_stream.sv
// Directed bench for matrix_memory_stream (DEPTH=6): reads, forwarding, generator,
// stalled load, back-pressured store and mid-load reset.
module tb_matrix_memory_stream;
  localparam int DIM = 4, DATA_W = 32, DEPTH = 6, CONST_W = 16;
  localparam int NEL = DIM * DIM, ROW_W = DIM * DATA_W, MAT_W = NEL * DATA_W;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  matrix_memory_stream_if #(.DIM(DIM), .DATA_W(DATA_W), .DEPTH(DEPTH), .CONST_W(CONST_W)) bus ();

  matrix_memory_stream #(.DIM(DIM), .DATA_W(DATA_W), .DEPTH(DEPTH), .CONST_W(CONST_W)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_mat(input string tag, input logic [MAT_W-1:0] obs, input logic [MAT_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_row(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // elem[i][j] = base + 16*i + j, element [0][0] in the MSBs
  function automatic logic [MAT_W-1:0] pat(input int base);
    logic [MAT_W-1:0] m;
    m = '0;
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++)
        m[(NEL-1-(i*DIM+j))*DATA_W +: DATA_W] = DATA_W'(base + 16*i + j);
    return m;
  endfunction

  function automatic logic [MAT_W-1:0] gen(input logic [DATA_W-1:0] c, input bit diag_only);
    logic [MAT_W-1:0] m;
    m = '0;
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++)
        if (!diag_only || i == j) m[(NEL-1-(i*DIM+j))*DATA_W +: DATA_W] = c;
    return m;
  endfunction

  function automatic logic [ROW_W-1:0] row_of(input logic [MAT_W-1:0] m, input int r);
    return m[(DIM-1-r)*ROW_W +: ROW_W];
  endfunction

  initial begin
    logic [MAT_W-1:0] m3, m4, m_ld, m_new, m_junk;
    logic [6:0] rdy_seq;
    int r;
    m3     = pat(0);
    m4     = pat(32'h4000);
    m_ld   = pat(32'h100);
    m_new  = pat(32'h7700);
    m_junk = pat(32'h55000);
    rdy_seq = 7'b1101001;

    rst_n = 1'b0;
    bus.rd1_idx = '0; bus.rd2_idx = '0; bus.gen_mode = 2'b00; bus.gen_const = '0;
    bus.wr_en = 1'b0; bus.wr_idx = '0; bus.wr_data = '0;
    bus.ld_start = 1'b0; bus.ld_idx = '0; bus.ld_valid = 1'b0; bus.ld_row = '0;
    bus.st_start = 1'b0; bus.st_idx = '0; bus.st_ready = 1'b0;
    #12;
    chk_bit("rst_st_valid", bus.st_valid, 1'b0);
    chk_bit("rst_ld_ready", bus.ld_ready, 1'b0);
    chk_bit("rst_ld_done", bus.ld_done, 1'b0);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      bus.rd1_idx = 3'(i);
      #1;
      chk_mat($sformatf("rst_slot%0d", i), bus.rd1_data, '0);
    end

    // full write with same-cycle forwarding
    bus.wr_en = 1'b1; bus.wr_idx = 3'd3; bus.wr_data = m3; bus.rd1_idx = 3'd3; bus.rd2_idx = 3'd3;
    #1;
    chk_mat("fwd_rd1", bus.rd1_data, m3);
    chk_mat("fwd_rd2", bus.rd2_data, m3);
    tick();
    bus.wr_en = 1'b0;
    #1;
    chk_mat("mem_rd1", bus.rd1_data, m3);
    bus.rd1_idx = 3'd2;
    #1;
    chk_mat("other_slot", bus.rd1_data, '0);

    // generator
    bus.gen_const = 16'd5; bus.gen_mode = 2'b10;
    #1; chk_mat("gen_diag", bus.rd2_data, gen(32'd5, 1'b1));
    bus.gen_mode = 2'b01;
    #1; chk_mat("gen_bcast", bus.rd2_data, gen(32'd5, 1'b0));
    bus.gen_const = 16'h8001;
    #1; chk_mat("gen_zext", bus.rd2_data, gen(32'h0000_8001, 1'b0));
    bus.gen_mode = 2'b11;
    #1; chk_mat("gen_zero", bus.rd2_data, '0);
    bus.gen_mode = 2'b00;

    // row-serial load of slot 2 with a valid gap and a competing write to slot 4
    bus.ld_start = 1'b1; bus.ld_idx = 3'd2;
    tick();
    bus.ld_start = 1'b0;
    chk_bit("ld_ready_active", bus.ld_ready, 1'b1);
    bus.ld_valid = 1'b1; bus.ld_row = row_of(m_ld, 0);
    tick();
    bus.ld_valid = 1'b0;
    tick();
    bus.ld_valid = 1'b1; bus.ld_row = row_of(m_ld, 1);
    tick();
    bus.ld_row = row_of(m_ld, 2); bus.wr_en = 1'b1; bus.wr_idx = 3'd4; bus.wr_data = m4;
    #1;
    chk_bit("ld_stall_on_wr", bus.ld_ready, 1'b0);
    tick();
    bus.wr_en = 1'b0;
    #1;
    chk_bit("ld_ready_resume", bus.ld_ready, 1'b1);
    tick();
    bus.ld_row = row_of(m_ld, 3);
    chk_bit("ld_done_early", bus.ld_done, 1'b0);
    tick();
    bus.ld_valid = 1'b0;
    chk_bit("ld_done_pulse", bus.ld_done, 1'b1);
    chk_bit("ld_ready_idle", bus.ld_ready, 1'b0);
    tick();
    chk_bit("ld_done_once", bus.ld_done, 1'b0);
    bus.rd1_idx = 3'd2; bus.rd2_idx = 3'd4;
    #1;
    chk_mat("ld_slot2", bus.rd1_data, m_ld);
    chk_mat("wr_slot4", bus.rd2_data, m4);

    // store slot 3 under back-pressure, overwriting slot 3 mid-stream
    bus.st_start = 1'b1; bus.st_idx = 3'd3;
    tick();
    bus.st_start = 1'b0;
    r = 0;
    for (int k = 0; k < 7; k++) begin
      bus.st_ready = rdy_seq[k];
      bus.wr_en = (k == 1); bus.wr_idx = 3'd3; bus.wr_data = m_new;
      #1;
      chk_bit($sformatf("st_valid_c%0d", k), bus.st_valid, 1'b1);
      chk_row($sformatf("st_row_c%0d", k), bus.st_row, row_of(m3, r));
      chk_bit($sformatf("st_last_c%0d", k), bus.st_last, r == DIM - 1);
      tick();
      if (rdy_seq[k]) r++;
    end
    bus.wr_en = 1'b0; bus.st_ready = 1'b0;
    #1;
    chk_bit("st_valid_end", bus.st_valid, 1'b0);
    bus.rd1_idx = 3'd3;
    #1;
    chk_mat("slot3_new", bus.rd1_data, m_new);

    // reset during the second load beat
    bus.ld_start = 1'b1; bus.ld_idx = 3'd2;
    tick();
    bus.ld_start = 1'b0; bus.ld_valid = 1'b1; bus.ld_row = '1;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk_bit("rst_mid_ld_ready", bus.ld_ready, 1'b0);
    bus.rd1_idx = 3'd2; bus.rd2_idx = 3'd3;
    #1;
    chk_mat("rst_mid_slot2", bus.rd1_data, '0);
    chk_mat("rst_mid_slot3", bus.rd2_data, '0);
    tick();
    rst_n = 1'b1;
    tick();
    chk_bit("post_rst_ld_ready", bus.ld_ready, 1'b0);
    chk_bit("post_rst_st_valid", bus.st_valid, 1'b0);
    bus.ld_valid = 1'b0;

    // write to an index beyond the last slot must be dropped
    bus.wr_en = 1'b1; bus.wr_idx = 3'(DEPTH); bus.wr_data = m_junk;
    tick();
    bus.wr_en = 1'b0;
    for (int i = 0; i <= DEPTH; i++) begin
      bus.rd1_idx = 3'(i);
      #1;
      chk_mat($sformatf("oob_drop_slot%0d", i), bus.rd1_data, '0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
